// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the serial pattern transmitter and its benches.
package sequence_generator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    GAP_WAIT = 2'd2
  } state_t;

  // Common preamble used by generator and detector benches alike.
  localparam logic [3:0] DEFAULT_PATTERN = 4'b0101;

  // Gap counter needs at least one bit even when no gap is configured.
  function automatic int gap_cnt_width(input int gap);
    int w;
    w = $clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sequence_generator_down_counter.sv
// Loadable down counter with zero flag; saturates at zero instead of wrapping.
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first,
// repeat_cnt times, with GAP idle cycles between repetitions.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [7:0]       repeat_cnt,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int GAP_W = gap_cnt_width(GAP);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t state, state_next;

  logic [WIDTH-1:0] shreg;
  logic             shreg_load;

  logic             idx_load, idx_en, idx_zero;
  logic [IDX_W-1:0] idx_count, idx_prev;
  logic             gap_load, gap_en, gap_zero;
  logic [GAP_W-1:0] gap_count;
  logic             rep_load, rep_en, rep_zero;
  logic [7:0]       rep_count;

  logic dout_next, dvalid_next, busy_next, done_next;
  logic unused_flags;

  down_counter #(.WIDTH(IDX_W)) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (idx_load),
    .en         (idx_en),
    .load_value (IDX_LAST),
    .count      (idx_count),
    .zero       (idx_zero)
  );

  down_counter #(.WIDTH(GAP_W)) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gap_load),
    .en         (gap_en),
    .load_value (GAP_LOAD),
    .count      (gap_count),
    .zero       (gap_zero)
  );

  down_counter #(.WIDTH(8)) u_rep (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (rep_load),
    .en         (rep_en),
    .load_value (repeat_cnt),
    .count      (rep_count),
    .zero       (rep_zero)
  );

  assign unused_flags = ^{gap_count, rep_zero};
  assign idx_prev     = idx_count - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shreg_load) begin
      shreg <= pattern;
    end
  end

  // Outputs are registered from the next-state decision, so the counters and
  // state always describe the bit currently on dout.
  always_comb begin
    state_next  = state;
    dout_next   = 1'b0;
    dvalid_next = 1'b0;
    done_next   = 1'b0;
    shreg_load  = 1'b0;
    idx_load    = 1'b0;
    idx_en      = 1'b0;
    gap_load    = 1'b0;
    gap_en      = 1'b0;
    rep_load    = 1'b0;
    rep_en      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          shreg_load = 1'b1;
          rep_load   = 1'b1;
          if (repeat_cnt != 8'd0) begin
            state_next  = SHIFT;
            idx_load    = 1'b1;
            dout_next   = pattern[WIDTH-1];
            dvalid_next = 1'b1;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (!idx_zero) begin
          idx_en      = 1'b1;
          dout_next   = shreg[idx_prev];
          dvalid_next = 1'b1;
        end else begin
          rep_en = 1'b1;
          if (rep_count == 8'd1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (GAP == 0) begin
            idx_load    = 1'b1;
            dout_next   = shreg[WIDTH-1];
            dvalid_next = 1'b1;
          end else begin
            state_next = GAP_WAIT;
            gap_load   = 1'b1;
          end
        end
      end

      GAP_WAIT: begin
        if (gap_zero) begin
          state_next  = SHIFT;
          idx_load    = 1'b1;
          dout_next   = shreg[WIDTH-1];
          dvalid_next = 1'b1;
        end else begin
          gap_en = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      dout   <= dout_next;
      dvalid <= dvalid_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter: captures a WIDTH-bit pattern and a repeat count on `start`, then drives the pattern MSB-first on `dout`, one bit per clock. Between repetitions it optionally inserts GAP idle cycles. It is the transmit-side counterpart to the serial sequence detectors, so their `din` input can be driven directly from `dout` for loopback test and for protocol preambles.

## Interface
- `WIDTH`, default 4: pattern length in bits, minimum 2.
- `GAP`, default 0: idle cycles between consecutive repetitions; 0 means back-to-back.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `start`  in  1  request a transmission; sampled only when idle.
- `pattern`  in  WIDTH  bits to send; bit WIDTH-1 is sent first.
- `repeat_cnt`  in  8  number of pattern repetitions, 0..255.
- `dout`  out  1  serial data; 0 whenever `dvalid`=0.
- `dvalid`  out  1  high in every cycle that carries a pattern bit.
- `busy`  out  1  high while a transmission is in progress.
- `done`  out  1  one-cycle pulse when a transmission completes.

## Operation
- FSM states: IDLE, SHIFT, GAP_WAIT.
- **IDLE:** on `start`=1, capture `pattern` into the shift register and `repeat_cnt` into the repetition counter.
  - If `repeat_cnt`≠0, go to SHIFT with bit index = WIDTH-1.
  - If `repeat_cnt`=0, stay in IDLE and pulse `done` next cycle. No bits are emitted.
- **SHIFT:** each cycle drives `dout`=captured[bit index] with `dvalid`=1, then decrements the bit index.
  - When index 0 is sent, decrement the repetition counter.
  - If the counter is now 0, go to IDLE and pulse `done`.
  - Else if GAP=0, reload the index to WIDTH-1 and stay in SHIFT.
  - Else go to GAP_WAIT.
- **GAP_WAIT:** lasts exactly GAP cycles with `dout`=0 and `dvalid`=0, then returns to SHIFT with index WIDTH-1.
- `start` is ignored while `busy`=1. Changes to `pattern` and `repeat_cnt` after capture have no effect.
- `start` is accepted in the cycle in which `done` is high, because the FSM is already in IDLE.
- When `rst_n` falls (at any time, including mid-transmission), all state is cleared immediately and the partial pattern is abandoned. No `done` pulse is produced.
- Reset values: `dout`=0, `dvalid`=0, `busy`=0, `done`=0, state=IDLE, all counters 0.

## Timing
- All outputs are registered.
- If `start` is sampled at edge k, the first bit is valid in cycle k+1 and `busy` rises in cycle k+1.
- `busy` stays high for N·WIDTH + (N-1)·GAP cycles, where N = `repeat_cnt`.
- `done`=1 in the first cycle after the last bit, in the same cycle that `busy` falls. `done` never overlaps `dvalid`.
- With `repeat_cnt`=0, `done` is high in cycle k+1 and `busy` never rises.
- Counter widths:
  - bit index: clog2(WIDTH)
  - gap counter: clog2(GAP+1), with a minimum of 1 bit
  - repetition counter: 8 bits, with no wrap (loading 0 is handled as the special case above)

## Structure
- Shared package holds:
  - the state encoding localparams (IDLE=0, SHIFT=1, GAP_WAIT=2, in a 2-bit state register)
  - the default test pattern constant 4'b0101, so generator and detector benches share it
- One sub-module, `down_counter`:
  - parameterised width
  - load value, load, and enable inputs
  - a `zero` flag output
  - instantiated three times, for bit index, gap, and repetitions
- The FSM and the output registers stay in `sequence_generator`.

## Test plan
- **Reset:** assert `rst_n`=0 in the middle of the second bit of pattern 0101.
  - Required: `dout`, `dvalid`, `busy`, `done` read 0 before the next clock edge.
  - Required: after release, there is no `done` pulse and the next `start` works.
- **Single pattern, no gap:** `pattern`=4'b0101, `repeat_cnt`=1, GAP=0.
  - Required: `dout`=0,1,0,1 in cycles k+1..k+4 with `dvalid`=1.
  - Required: `done`=1 in cycle k+5, and `busy` is high for exactly 4 cycles.
- **Repeats with gap:** `pattern`=4'b1100, `repeat_cnt`=3, GAP=2.
  - Required: `dout`/`dvalid` sequence is 1100, then 2 idle cycles, then 1100, then 2 idle cycles, then 1100.
  - Required: `busy` is high for 16 cycles, followed by a single `done`.
- **Start while busy:** during a transmission of 0101, pulse `start` with `pattern`=4'b1111.
  - Required: the output remains 0101 and the ignored start leaves no trace.
- **Zero repeat and back-to-back start:**
  - `repeat_cnt`=0: `done` is high in cycle k+1, and `dvalid` and `busy` stay 0.
  - `start` held high during the `done` cycle: the next transmission begins in the following cycle.
- **Loopback:** connect `dout` to the detector `din` and send 0101 with `repeat_cnt`=1.
  - Required: the detector flags exactly once, and the bench scoreboard matches the per-bit `dout` trace.
